fetch_unit: RTL

In-order instruction fetch stage for the ARM core, directly upstream of the control unit. It holds the fetch PC, issues word requests to instruction memory over a ready/valid interface, and buffers returned words in a small prefetch FIFO. The head instruction is presented to decode with its control-unit fields (Cond, Op, Funct, Rd) pre-split and its architectural PC+8. A redirect flushes the FIFO, squashes in-flight responses and restarts fetch at the target.

---
 rtl/fetch_unit.sv | 78 +++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: in-order ARM fetch stage with credit-limited imem requests, prefetch FIFO
// and redirect squashing of in-flight responses.
module fetch_unit #(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [3:0]        cond,
  output logic [1:0]        op,
  output logic [5:0]        funct,
  output logic [3:0]        rd,
  output logic [ADDR_W-1:0] pc_plus8,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [ADDR_W-1:0] fetch_pc, head_pc, target;
  logic [31:0]       mem [DEPTH];
  logic [AW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count, outstanding, discard;
  logic [CW:0]       credits;
  logic              accept, resp, push, pop;
  // Buffered words plus in-flight requests may never exceed the FIFO size.
  assign credits     = {1'b0, outstanding} + {1'b0, count};
  assign imem_req    = !reset && !redirect && credits < (CW + 1)'(DEPTH);
  assign imem_addr   = fetch_pc;
  assign accept      = imem_req && imem_ready;
  assign resp        = imem_rvalid && outstanding != '0;
  assign push        = resp && discard == '0;
  assign instr_valid = count != '0;
  assign pop         = instr_valid && instr_ready;
  assign instr       = instr_valid ? mem[rd_ptr] : '0;
  assign cond        = instr[31:28];
  assign op          = instr[27:26];
  assign funct       = instr[25:20];
  assign rd          = instr[15:12];
  assign pc_plus8    = head_pc + ADDR_W'(8);
  assign target      = redirect_pc & ~ADDR_W'(3);
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      head_pc     <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
    end else if (redirect) begin
      fetch_pc    <= target;
      head_pc     <= target;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= outstanding - CW'(resp);
      discard     <= outstanding - CW'(resp);
    end else begin
      if (accept) fetch_pc <= fetch_pc + ADDR_W'(4);
      if (pop) head_pc <= head_pc + ADDR_W'(4);
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push) mem[wr_ptr] <= imem_rdata;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (resp && discard != '0) discard <= discard - 1'b1;
      count       <= count + CW'(push) - CW'(pop);
      outstanding <= outstanding + CW'(accept) - CW'(resp);
    end
  end
endmodule
